multi_read_port_ram: RTL
========================

# multi_read_port_ram

Parametrised single-write, N-read-port RAM for the processing datapath. Read ports are registered, with per-port enables and valid flags. Same-address read/write collisions follow a selectable ordering. A built-in clear sequencer zeroes the whole array after reset or on request. It generalises the fixed eight-port asynchronous-read RAM and gives synthesis a fully synchronous memory with deterministic contents.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 10, address width; depth MEM_SIZE = 2**ADDR_WIDTH
- NUM_RD, 8, number of independent read ports (>=1)
- RD_MODE, 0, collision ordering: 0 = read-first (old data), 1 = write-first (bypass new data)
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset release; 0 = contents undefined after reset

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear_i  in  1  single-cycle request to zero the whole array
- busy_o  out  1  clear sweep in progress
- write_en_i  in  1  write strobe
- write_addr_i  in  ADDR_WIDTH  write address
- data_i  in  DATA_WIDTH  write data
- read_en_i  in  NUM_RD  per-port read strobe
- read_addr_i  in  NUM_RD*ADDR_WIDTH  port k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_o  out  NUM_RD*DATA_WIDTH  port k data at bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_o  out  NUM_RD  per-port read-data valid

## Operation
- The FSM has two states: IDLE and CLEAR. Clear counter clr_cnt is ADDR_WIDTH bits wide.
- Reset (rst=1):
  - data_o = 0 and valid_o = 0.
  - clr_cnt = 0.
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - busy_o = (state==CLEAR).
  - No array writes occur while rst=1.
- CLEAR:
  - Each cycle with rst=0: mem[clr_cnt] <= 0, then clr_cnt increments.
  - When clr_cnt==MEM_SIZE-1 is written, state becomes IDLE and clr_cnt becomes 0.
  - write_en_i, read_en_i and clear_i are ignored. valid_o = 0. data_o holds.
- IDLE:
  - clear_i=1 moves the FSM to CLEAR with clr_cnt=0. A write in that same cycle is still performed and is then overwritten by the sweep.
  - write_en_i=1: mem[write_addr_i] <= data_i.
  - Per port k with read_en_i[k]=1:
    - data_o[k] <= mem[addr_k] and valid_o[k] <= 1.
    - Exception: if write_en_i=1, write_addr_i==addr_k and RD_MODE=1, then data_o[k] <= data_i.
    - With RD_MODE=0, a port reads the pre-write content.
  - Per port k with read_en_i[k]=0: valid_o[k] <= 0 and data_o[k] holds its previous value.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.
- Reset mid-sweep: the sweep restarts from address 0 after release (if CLEAR_ON_RESET). Otherwise the FSM goes to IDLE with contents partially cleared.

## Timing
- Read latency is 1 cycle. The address presented at edge n gives data_o and valid_o at edge n+1.
- Write-to-read: a read at edge n+1 after a write at edge n returns the new data in either RD_MODE.
- Clear duration is exactly MEM_SIZE cycles with rst=0.
  - busy_o rises the cycle after clear_i is accepted, or stays high from reset.
  - busy_o falls MEM_SIZE cycles after the first sweep cycle.
- First valid access: the read or write accepted in the first cycle busy_o=0.
- valid_o is a one-cycle pulse per accepted read. There is no backpressure.

## Test plan
Configuration: ADDR_WIDTH=4, NUM_RD=4, DATA_WIDTH=32.
1. Reset clear: hold rst 3 cycles, then release -> busy_o=1 for exactly 16 cycles. Afterwards, reading addresses 0..15 on all ports returns 0x00000000 with valid_o=4'b1111.
2. Broadcast read: write 0xDEADBEEF to addr 5, then read addr 5 on all 4 ports next cycle -> one cycle later data_o = 4×0xDEADBEEF and valid_o=4'b1111. The following idle cycle gives valid_o=0 with data held.
3. Collision: addr 3 holds 0x22. Write 0x11 to addr 3 while port 2 reads addr 3 in the same cycle -> RD_MODE=0 returns 0x22, RD_MODE=1 returns 0x11. A read of addr 3 the next cycle returns 0x11 in both modes.
4. Requested clear: fill memory with non-zero data, then pulse clear_i. During busy_o, write 0x55 to addr 7 and assert read_en_i=4'b1111 -> valid_o stays 0 and busy_o=1 for 16 cycles. Afterwards addr 7 reads 0.
5. Reset mid-sweep: assert rst when clr_cnt=8, hold 2 cycles, then release -> busy_o stays high for a further 16 cycles. All addresses read 0.
6. CLEAR_ON_RESET=0: release reset -> busy_o=0 immediately. A write of 0xA5A5A5A5 to addr 15 followed by a read on port 0 returns 0xA5A5A5A5 after 1 cycle.

Source files
------------

// File: rtl/multi_read_port_ram.sv
// Single-write, multi-read-port RAM with registered read ports,
// selectable read/write collision ordering and a built-in clear sweep.
module multi_read_port_ram #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned NUM_RD         = 8,
  parameter int unsigned RD_MODE        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  output logic                           busy_o,
  input  logic                           write_en_i,
  input  logic [ADDR_WIDTH-1:0]          write_addr_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [NUM_RD-1:0]              read_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   read_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   data_o,
  output logic [NUM_RD-1:0]              valid_o
);

  localparam int unsigned MEM_SIZE = 2**ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  // The sweep ends on the all-ones address, i.e. MEM_SIZE-1.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]       clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]       mem_q [MEM_SIZE];
  logic [NUM_RD*DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_RD-1:0]           valid_q, valid_d;
  logic                        clearing;

  assign clearing = (state_q == ST_CLEAR);
  assign busy_o   = clearing;
  assign data_o   = data_q;
  assign valid_o  = valid_q;

  // Next-state for the clear sequencer: sweep every address once, then idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clearing) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end else if (clear_i) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array write port: the sweep owns the port while clearing, no writes in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (write_en_i) begin
        mem_q[write_addr_i] <= data_i;
      end
    end
  end

  // Per-port read data: disabled ports hold data and drop valid; write-first
  // mode forwards the incoming write on an address match.
  always_comb begin
    data_d  = data_q;
    valid_d = '0;
    if (!clearing) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        if (read_en_i[k]) begin
          valid_d[k] = 1'b1;
          if ((RD_MODE != 0) && write_en_i &&
              (write_addr_i == read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
            data_d[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
          end else begin
            data_d[k*DATA_WIDTH +: DATA_WIDTH] =
              mem_q[read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
          end
        end
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule
